test_mailbox: RTL and testbench

//   Memory-mapped responder the processor's self-checking programs write to; the bench end of
//   the program-level tests. Decodes data-bus stores at BASE_ADDR, tracks test state
//   (start/pass/fail/timeout), counts cycles, and buffers checkpoint words in a FIFO drained
//   by the bench through a valid/ready port. Sits beside data memory on the processor's data bus.

---
 rtl/test_mailbox_pkg.sv | 33 +++
 rtl/test_mailbox_sync_fifo.sv | 56 +++++
 rtl/test_mailbox.sv | 110 +++++++++++
 tb/tb_test_mailbox.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/test_mailbox_pkg.sv
// Shared encodings for the test mailbox: FSM states, register word offsets, STATUS fields.
package test_mailbox_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PASSED  = 3'd2,
        ST_FAILED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } mbox_state_e;

    // Word offsets (byte offset >> 2) inside the register window.
    localparam logic [29:0] OFS_CTRL   = 30'd0;
    localparam logic [29:0] OFS_RESULT = 30'd1;
    localparam logic [29:0] OFS_LOG    = 30'd2;
    localparam logic [29:0] OFS_STATUS = 30'd3;
    localparam logic [29:0] OFS_CYCLES = 30'd4;
    localparam logic [29:0] NUM_REGS   = 30'd5;

    localparam int STATUS_OVF_BIT = 31;
    localparam int STATUS_CNT_LSB = 8;

    function automatic logic [31:0] pack_status(input logic ovf, input logic [7:0] cnt,
                                                input logic [2:0] st);
        logic [31:0] s;
        s = '0;
        s[STATUS_OVF_BIT] = ovf;
        s[STATUS_CNT_LSB +: 8] = cnt;
        s[2:0] = st;
        return s;
    endfunction

endpackage

// File: rtl/test_mailbox_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with flush; head is valid whenever not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pop is qualified by non-empty, so push+pop on empty is a plain push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/test_mailbox.sv
// Memory-mapped test mailbox: decodes stores at BASE_ADDR, runs the test-state FSM with a
// watchdog and cycle counter, and buffers LOG words in a FIFO drained over log_valid/log_ready.
module test_mailbox
    import test_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_FF00,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          WATCHDOG_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_data,
    output logic [2:0]  state,
    output logic        done,
    output logic [31:0] fail_code,
    output logic [31:0] cycle_count,
    output logic        overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mbox_state_e state_q;
    logic [31:0] fail_code_q, cycle_q;
    logic        ovf_q;

    logic [29:0]   wofs;
    logic          wr_ctrl, wr_result, wr_log, start;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    // Reads are side-effect free and byte lanes are ignored.
    assign unused_bits = ^{addr[1:0], mem_read};

    // Subtracting the base makes addresses below the window wrap to large values.
    assign wofs = addr[31:2] - BASE_ADDR[31:2];
    assign sel  = (wofs < NUM_REGS);

    assign wr_ctrl   = mem_write && sel && (wofs == OFS_CTRL);
    assign wr_result = mem_write && sel && (wofs == OFS_RESULT);
    assign wr_log    = mem_write && sel && (wofs == OFS_LOG);
    assign start     = wr_ctrl && write_data[0];

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_log_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_log),
        .pop_i   (log_ready),
        .flush_i (start),
        .din_i   (write_data),
        .dout_o  (log_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign log_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fail_code_q <= '0;
            cycle_q     <= '0;
            ovf_q       <= 1'b0;
        end else if (start) begin
            state_q     <= ST_RUNNING;
            fail_code_q <= '0;
            cycle_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (wr_log && fifo_full && !log_ready) ovf_q <= 1'b1;
            if (state_q == ST_RUNNING) begin
                if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
                // A RESULT landing on the expiry cycle beats the watchdog.
                if (wr_result) begin
                    state_q     <= (write_data == '0) ? ST_PASSED : ST_FAILED;
                    fail_code_q <= write_data;
                end else if (cycle_q == 32'(WATCHDOG_CYCLES - 1)) begin
                    state_q <= ST_TIMEOUT;
                end
            end
        end
    end

    assign state       = state_q;
    assign done        = (state_q == ST_PASSED) || (state_q == ST_FAILED) ||
                         (state_q == ST_TIMEOUT);
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;
    assign overflow    = ovf_q;

    always_comb begin
        read_data = '0;
        if (sel) begin
            if (wofs == OFS_STATUS) begin
                read_data = pack_status(ovf_q, 8'(fifo_count), state_q);
            end else if (wofs == OFS_CYCLES) begin
                read_data = cycle_q;
            end
        end
    end

endmodule

// File: tb/tb_test_mailbox.sv
// Directed bench for test_mailbox: hand-computed expectations checked by immediate assertions.
module tb_test_mailbox;
    localparam logic [31:0] BASE   = 32'h0000_FF00;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_RES  = BASE + 32'h04;
    localparam logic [31:0] A_LOG  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_CYC  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0, mem_read = 1'b0, log_ready = 1'b0;
    logic [31:0] addr = '0, write_data = '0;
    logic [31:0] read_data, log_data, fail_code, cycle_count;
    logic        sel, log_valid, done, overflow;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    test_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .WATCHDOG_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .write_data(write_data), .read_data(read_data), .sel(sel),
        .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data),
        .state(state), .done(done), .fail_code(fail_code),
        .cycle_count(cycle_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_data = d; mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0; addr = '0; write_data = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; mem_read = 1'b1;
        #1;
        d = read_data;
        mem_read = 1'b0; addr = '0;
    endtask

    initial begin
        logic [31:0] r;

        // 1: reset state
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_log_valid", 32'(log_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rd(A_STAT, r); chk("rst_status", r, 32'd0);
        rd(A_CYC, r);  chk("rst_cycles", r, 32'd0);
        cyc(1);
        rd(32'h0, r);  chk("rd_addr0", r, 32'd0);
        addr = 32'h0; #1; chk("sel_addr0", 32'(sel), 32'd0);
        addr = A_CYC + 32'd3; #1; chk("sel_last_byte", 32'(sel), 32'd1);
        addr = A_CYC + 32'd4; #1; chk("sel_past_end", 32'(sel), 32'd0);
        addr = '0;

        // 2: pass after five idle cycles
        cyc(1);
        wr(A_CTRL, 32'd1);
        chk("t2_running", 32'(state), 32'd1);
        chk("t2_cnt0", cycle_count, 32'd0);
        cyc(5);
        chk("t2_cnt5", cycle_count, 32'd5);
        wr(A_RES, 32'd0);
        chk("t2_passed", 32'(state), 32'd2);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cnt6", cycle_count, 32'd6);
        cyc(3);
        chk("t2_frozen", cycle_count, 32'd6);
        rd(A_CYC, r);  chk("t2_cycles_reg", r, 32'd6);
        rd(A_STAT, r); chk("t2_status", r, 32'h0000_0002);

        // 3: log words drained in order, then push+pop on empty is push only
        cyc(1);
        wr(A_CTRL, 32'd1);
        wr(A_LOG, 32'hFEFE_0001);
        wr(A_LOG, 32'hFEFE_0002);
        wr(A_LOG, 32'hFEFE_0003);
        rd(A_STAT, r); chk("t3_status", r, 32'h0000_0301);
        chk("t3_valid", 32'(log_valid), 32'd1);
        log_ready = 1'b1;
        chk("t3_w1", log_data, 32'hFEFE_0001);
        cyc(1); chk("t3_w2", log_data, 32'hFEFE_0002);
        cyc(1); chk("t3_w3", log_data, 32'hFEFE_0003);
        cyc(1); chk("t3_empty", 32'(log_valid), 32'd0);
        wr(A_LOG, 32'h0000_ABCD);
        chk("t3_bypass_valid", 32'(log_valid), 32'd1);
        chk("t3_bypass_data", log_data, 32'h0000_ABCD);
        cyc(1); chk("t3_bypass_popped", 32'(log_valid), 32'd0);
        log_ready = 1'b0;

        // 4: RESULT ignored in IDLE, failure is final
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        wr(A_RES, 32'h0000_0BAD);
        chk("t4_idle_ignore", 32'(state), 32'd0);
        chk("t4_idle_code", fail_code, 32'd0);
        wr(A_CTRL, 32'd1);
        wr(A_RES, 32'h0000_0BAD);
        chk("t4_failed", 32'(state), 32'd3);
        chk("t4_code", fail_code, 32'h0000_0BAD);
        wr(A_RES, 32'd0);
        chk("t4_stays_failed", 32'(state), 32'd3);
        chk("t4_code_kept", fail_code, 32'h0000_0BAD);
        wr(A_CTRL, 32'd0);
        chk("t4_ctrl0_noop", 32'(state), 32'd3);

        // 5: watchdog expiry, and RESULT on the expiry cycle wins
        wr(A_CTRL, 32'd1);
        chk("t5_code_clr", fail_code, 32'd0);
        cyc(15);
        chk("t5_run15", 32'(state), 32'd1);
        cyc(1);
        chk("t5_timeout", 32'(state), 32'd4);
        chk("t5_cnt16", cycle_count, 32'd16);
        chk("t5_done", 32'(done), 32'd1);
        wr(A_CTRL, 32'd1);
        cyc(15);
        wr(A_RES, 32'd0);
        chk("t5_result_wins", 32'(state), 32'd2);

        // 6: overflow, full push+pop, flush and mid-test reset
        wr(A_CTRL, 32'd1);
        for (int i = 0; i < 8; i++) wr(A_LOG, 32'h100 + 32'(i));
        rd(A_STAT, r); chk("t6_full", r, 32'h0000_0801);
        wr(A_LOG, 32'h0000_0108);
        chk("t6_overflow", 32'(overflow), 32'd1);
        rd(A_STAT, r); chk("t6_status_ovf", r, 32'h8000_0801);
        log_ready = 1'b1;
        wr(A_LOG, 32'h0000_0200);
        log_ready = 1'b0;
        rd(A_STAT, r); chk("t6_full_pushpop", r, 32'h8000_0801);
        chk("t6_head_after_pop", log_data, 32'h0000_0101);
        wr(A_CTRL, 32'd1);
        chk("t6_flush_valid", 32'(log_valid), 32'd0);
        chk("t6_flush_ovf", 32'(overflow), 32'd0);
        wr(A_LOG, 32'h0000_0300);
        wr(A_LOG, 32'h0000_0301);
        rst_n = 1'b0;
        wr(A_LOG, 32'h0000_0302);
        rst_n = 1'b1;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_valid", 32'(log_valid), 32'd0);
        chk("t6_rst_cycles", cycle_count, 32'd0);
        rd(A_STAT, r); chk("t6_rst_status", r, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
